// File: rtl/router_out_arbiter_pkg.sv
// Shared router definitions: default sizes, arbiter state encoding and a
// modulo-increment helper used when advancing the round-robin pointer.
package router_out_arbiter_pkg;

  localparam int FLIT_W  = 8;
  localparam int NIN_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Next index after idx in a ring of n entries, with the wrap written out
  // so a non-power-of-2 ring never yields an index at or above n.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// Round-robin picker: returns the first asserted request scanning upward from
// ptr and wrapping modulo NIN. Purely combinational so the route-computation
// stage can reuse it.
module router_out_arbiter_rr_pick #(
  parameter int NIN = 4,
  parameter int GW  = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic [NIN-1:0] req,
  input  logic [GW-1:0]  ptr,
  output logic [GW-1:0]  idx,
  output logic           any
);

  // Scan offsets 0..NIN-1 from ptr; the first hit wins.
  always_comb begin
    int j;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NIN; k++) begin
      j = int'(ptr) + k;
      if (j >= NIN) j = j - NIN;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = GW'(j);
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Packet-level round-robin arbiter for one router output link. A granted
// input owns the link until its last flit transfers; flits pass through
// combinationally and only the grant, pointer and state are registered.
module router_out_arbiter
  import router_out_arbiter_pkg::*;
#(
  parameter int NIN = NIN_DEF,
  parameter int DW  = FLIT_W,
  parameter int GW  = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN-1:0]    lvalid,
  input  logic [NIN-1:0]    llast,
  input  logic [NIN*DW-1:0] ldata,
  output logic [NIN-1:0]    lrdy,
  output logic              rvalid,
  output logic              rlast,
  output logic [DW-1:0]     rdata,
  input  logic              rrdy,
  output logic              busy,
  output logic [GW-1:0]     gnt_idx
);

  arb_state_t      state, state_n;
  logic [GW-1:0]   ptr, ptr_n;
  logic [GW-1:0]   gnt_n;
  logic [GW-1:0]   pick_idx;
  logic            pick_any;

  router_out_arbiter_rr_pick #(
    .NIN (NIN),
    .GW  (GW)
  ) u_pick (
    .req (lvalid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign busy = (state == LOCK);

  // State, round-robin pointer and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt_idx <= gnt_n;
    end
  end

  // Arbitrate in IDLE; in LOCK steer the granted input to the link until
  // its last flit is accepted downstream.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt_idx;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    lrdy    = '0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_n   = pick_idx;
          state_n = LOCK;
        end
      end
      LOCK: begin
        rvalid        = lvalid[gnt_idx];
        rlast         = llast[gnt_idx];
        rdata         = ldata[gnt_idx*DW +: DW];
        lrdy[gnt_idx] = rrdy;
        if (lvalid[gnt_idx] && rrdy && llast[gnt_idx]) begin
          state_n = IDLE;
          ptr_n   = GW'(wrap_next(int'(gnt_idx), NIN));
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
